fe_bf2i_pipe: RTL
=================

Name: fe_bf2i_pipe

Overview:
- Pipelined, runtime-configurable radix-2^2 BF2I butterfly for the front-end FFT datapath.
- Processes two complex lanes per valid sample: sum on lane 0, difference on lane 1.
- Lane 1 takes a trivial ±j rotation on alternate count phases.
- Adds over the combinational BF2I: registered output with valid, runtime direct/inverse select, frame sync, per-sample scaling with rounding, saturation, and a sticky overflow flag.

Parameters:
- NBW_IN, 8, input component width (signed).
- NBW_OUT, NBW_IN+1, output component width (signed).
- NBW_C, 2, phase counter width.
- BSEL, 0, counter bit that selects the rotation phase.
- NS_MAX, 2, maximum right-shift applied by scaling.

Ports:
- clk  in  1  clock.
- rst_async_n  in  1  asynchronous active-low reset.
- i_sync  in  1  frame start; clears the phase counter.
- i_valid  in  1  input sample valid.
- i_inv  in  1  0 = direct (-j), 1 = inverse (+j); sampled with i_valid.
- i_shift  in  $clog2(NS_MAX+1)  right-shift amount; sampled with i_valid.
- i_data  in  [1:0][1:0]xNBW_IN  [lane][0=I,1=Q] signed input.
- i_ovf_clr  in  1  clears o_ovf.
- o_valid  out  1  output valid.
- o_data  out  [1:0][1:0]xNBW_OUT  [lane][I/Q] signed output.
- o_ovf  out  1  sticky saturation flag.

Behaviour:
- Reset: count=0, all pipeline registers 0, o_valid=0, o_data=0, o_ovf=0.
- Phase counter:
  - i_sync=1: effective count for the current sample is 0. Next count = 1 if i_valid, else 0.
  - Otherwise count <= count + i_valid, wrapping modulo 2^NBW_C.
  - sel = effective_count[BSEL].
- Stage A (registered on i_valid only; holds otherwise):
  - Compute in NBW_IN+1 bits: s = d0 + d1, t = d0 - d1, per I/Q.
  - Lane 1 when sel=1: i_inv=0 gives (tQ, -tI); i_inv=1 gives (-tQ, tI). When sel=0, lane 1 is (tI, tQ).
  - Negation never overflows: t lies in [-(2^NBW_IN - 1), 2^NBW_IN - 1].
  - Also capture shift amount sh = min(i_shift, NS_MAX).
  - a_vld <= i_valid every cycle.
- Stage B (output register):
  - Per component: if sh>0, x' = (x + 2^(sh-1)) >>> sh (round half up, arithmetic shift); if sh=0, x' = x.
  - Compute x' in NBW_IN+2 bits, then saturate to [-2^(NBW_OUT-1), 2^(NBW_OUT-1)-1].
  - o_data updates only when a_vld=1 and holds otherwise.
  - o_valid <= a_vld.
- Latency: exactly 2 clk from i_valid to o_valid. Throughput: one sample per cycle. Gaps pass through as o_valid=0.
- Overflow:
  - Any saturated component on a valid sample sets o_ovf, visible in the same cycle as the corresponding o_valid.
  - i_ovf_clr clears o_ovf next cycle.
  - Simultaneous set and clear: set wins.
- i_sync without i_valid: counter cleared, no output generated.
- Reset mid-stream: in-flight samples discarded, o_valid=0 immediately (asynchronous).
- Default widths (NBW_OUT=NBW_IN+1, sh=0) never saturate.

Test Plan:
- Reset, then i_sync=1, i_valid=1, d0=(10,20), d1=(3,5), sh=0 -> 2 cycles later o_valid=1, lane0=(13,25), lane1=(7,15), o_ovf=0.
- Next valid with the same data, i_inv=0 (count=1, sel=1) -> lane1=(15,-7). Repeat with i_inv=1 -> lane1=(-15,7). Count=2 -> lane1=(7,15).
- d0=(127,-128), d1=(-128,127), sel=1, i_inv=0 -> lane0=(-1,-1), lane1=(-255,-255). With NBW_OUT=8 override -> lane1=(-128,-128), o_ovf=1 and stays 1 until i_ovf_clr. Clear and set in the same cycle -> o_ovf stays 1.
- sh=1: lane0 sums 13 and -13 -> 7 and -6. i_shift=3 with NS_MAX=2 -> treated as 2, so 13 -> 3.
- i_valid pattern 1,0,0,1 -> count advances only on valid samples; o_valid pattern 1,0,0,1 delayed by 2; o_data held during the gap.
- i_sync asserted on the 3rd valid sample -> that sample uses sel=0, following sample uses sel=1. Assert rst_async_n low mid-stream -> o_valid, o_data, o_ovf go 0 immediately.

Source files
------------

// File: rtl/fe_bf2i_pipe.sv
// fe_bf2i_pipe: pipelined radix-2^2 BF2I butterfly with trivial +/-j rotation, rounding scaler, saturation and sticky overflow.
module fe_bf2i_pipe #(
  parameter int NBW_IN  = 8,
  parameter int NBW_OUT = NBW_IN + 1,
  parameter int NBW_C   = 2,
  parameter int BSEL    = 0,
  parameter int NS_MAX  = 2,
  localparam int NBW_SH = NS_MAX > 0 ? $clog2(NS_MAX + 1) : 1
) (
  input  logic                             clk,
  input  logic                             rst_async_n,
  input  logic                             i_sync,
  input  logic                             i_valid,
  input  logic                             i_inv,
  input  logic [NBW_SH-1:0]                i_shift,
  input  logic [1:0][1:0][NBW_IN-1:0]      i_data,
  input  logic                             i_ovf_clr,
  output logic                             o_valid,
  output logic [1:0][1:0][NBW_OUT-1:0]     o_data,
  output logic                             o_ovf
);
  localparam int W    = NBW_IN + 2;
  localparam int OMAX = 2 ** (NBW_OUT - 1) - 1;
  localparam int OMIN = -(2 ** (NBW_OUT - 1));
  logic [NBW_C-1:0] cnt_q, cnt_d, eff;
  logic sel;
  logic signed [NBW_IN:0] x0 [2], x1 [2], s [2], t [2];
  logic [1:0][1:0][NBW_IN:0] a_q, a_d;
  logic [NBW_SH-1:0] sh_q, sh_d;
  logic a_vld_q, vld_q, ovf_q, ovf_d, sat_any;
  logic [1:0][1:0][NBW_OUT-1:0] dat_q, dat_d;
  logic signed [W-1:0] ext, bias, rnd;
  int y;
  always_comb begin
    eff   = i_sync ? '0 : cnt_q;
    cnt_d = i_sync ? NBW_C'(i_valid) : cnt_q + NBW_C'(i_valid);
    sel   = eff[BSEL];
    for (int c = 0; c < 2; c++) begin
      x0[c] = $signed({i_data[0][c][NBW_IN-1], i_data[0][c]});
      x1[c] = $signed({i_data[1][c][NBW_IN-1], i_data[1][c]});
      s[c]  = x0[c] + x1[c];
      t[c]  = x0[c] - x1[c];
    end
    a_d[0][0] = s[0];
    a_d[0][1] = s[1];
    a_d[1][0] = sel ? (i_inv ? -t[1] : t[1]) : t[0];
    a_d[1][1] = sel ? (i_inv ? t[0] : -t[0]) : t[1];
    sh_d = (i_shift > NBW_SH'(NS_MAX)) ? NBW_SH'(NS_MAX) : i_shift;
  end
  // Round half up by adding half an LSB of the shifted result before the arithmetic shift.
  always_comb begin
    sat_any = 1'b0;
    dat_d   = dat_q;
    ext     = '0;
    bias    = '0;
    rnd     = '0;
    y       = 0;
    for (int l = 0; l < 2; l++) begin
      for (int c = 0; c < 2; c++) begin
        ext  = $signed({a_q[l][c][NBW_IN], a_q[l][c]});
        bias = (sh_q == '0) ? '0 : $signed(W'(1) << (sh_q - NBW_SH'(1)));
        rnd  = (ext + bias) >>> sh_q;
        y    = int'(rnd);
        dat_d[l][c] = !a_vld_q ? dat_q[l][c] : y > OMAX ? NBW_OUT'(OMAX) : y < OMIN ? NBW_OUT'(OMIN) : NBW_OUT'(y);
        sat_any = sat_any | (a_vld_q & (y > OMAX || y < OMIN));
      end
    end
    ovf_d = sat_any ? 1'b1 : i_ovf_clr ? 1'b0 : ovf_q;
  end
  always_ff @(posedge clk or negedge rst_async_n) begin
    if (!rst_async_n) begin
      cnt_q   <= '0;
      a_q     <= '0;
      sh_q    <= '0;
      a_vld_q <= 1'b0;
      vld_q   <= 1'b0;
      dat_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (i_valid) begin
        a_q  <= a_d;
        sh_q <= sh_d;
      end
      a_vld_q <= i_valid;
      vld_q   <= a_vld_q;
      dat_q   <= dat_d;
      ovf_q   <= ovf_d;
    end
  end
  assign o_valid = vld_q;
  assign o_data  = dat_q;
  assign o_ovf   = ovf_q;
endmodule
